// File: rtl/radar_sweep_ranger_pkg.sv
// Shared definitions for the sweep ranger: FSM encoding, sweep limits and the
// r_theta field layout that polar_to_cartesian decodes.
package radar_sweep_ranger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_TRIGGER,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_REPORT,
    ST_ADVANCE
  } state_e;

  localparam int unsigned THETA_W      = 4;
  localparam int unsigned RANGE_W      = 8;
  localparam int unsigned RT_W         = THETA_W + RANGE_W;
  localparam int unsigned RT_RANGE_LSB = 0;
  localparam int unsigned RT_RANGE_MSB = RANGE_W - 1;
  localparam int unsigned RT_THETA_LSB = RANGE_W;
  localparam int unsigned RT_THETA_MSB = RT_W - 1;

  localparam logic [THETA_W-1:0] MAX_THETA_INDEX = 4'd12;
  localparam logic [RANGE_W-1:0] RANGE_MAX       = '1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [RT_W-1:0] pack_r_theta(input logic [THETA_W-1:0] theta,
                                                   input logic [RANGE_W-1:0] rng);
    logic [RT_W-1:0] rt;
    rt = '0;
    rt[RT_THETA_MSB:RT_THETA_LSB] = theta;
    rt[RT_RANGE_MSB:RT_RANGE_LSB] = rng;
    return rt;
  endfunction

endpackage

// File: rtl/echo_pulse_timer.sv
// Echo front end: 2-flop synchronizer, edge detection and a unit sub-counter
// feeding a saturating 8-bit range counter.
module echo_pulse_timer
  import radar_sweep_ranger_pkg::*;
#(
  parameter int unsigned CYCLES_PER_UNIT = 1566
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               echo_async,
  input  logic               clear,
  input  logic               count_en,
  output logic               echo_rise,
  output logic               echo_fall,
  output logic [RANGE_W-1:0] range
);

  localparam int unsigned SUB_W = cnt_width(CYCLES_PER_UNIT);

  logic               sync1_q, sync2_q, prev_q;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [RANGE_W-1:0] range_q, range_d;

  assign echo_rise = sync2_q & ~prev_q;
  assign echo_fall = ~sync2_q & prev_q;
  assign range     = range_q;

  // Only synchronized-high clocks are counted, so partial units are dropped.
  always_comb begin
    sub_d   = sub_q;
    range_d = range_q;
    if (clear) begin
      sub_d   = '0;
      range_d = '0;
    end else if (count_en && sync2_q) begin
      if (sub_q == SUB_W'(CYCLES_PER_UNIT - 1)) begin
        sub_d = '0;
        if (range_q != RANGE_MAX) begin
          range_d = range_q + 1'b1;
        end
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      sub_q   <= '0;
      range_q <= '0;
    end else begin
      sync1_q <= echo_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      sub_q   <= sub_d;
      range_q <= range_d;
    end
  end

endmodule

// File: rtl/radar_sweep_ranger.sv
// Servo-swept ultrasonic ranger: settles, triggers, times the echo and reports
// {theta, range} at each of 13 angles, ping-ponging between 0 and 12.
module radar_sweep_ranger
  import radar_sweep_ranger_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 27_000_000,
  parameter int unsigned TRIG_CYCLES     = 270,
  parameter int unsigned CYCLES_PER_UNIT = 1566,
  parameter int unsigned SETTLE_CYCLES   = 5_400_000,
  parameter int unsigned ECHO_TIMEOUT    = 810_000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               echo,
  output logic               trigger,
  output logic [THETA_W-1:0] theta_index,
  output logic [RT_W-1:0]    r_theta,
  output logic               r_theta_valid,
  output logic               sweep_done
);

  if (CLK_HZ == 0 || TRIG_CYCLES == 0 || CYCLES_PER_UNIT == 0 ||
      SETTLE_CYCLES == 0 || ECHO_TIMEOUT == 0) begin : g_param_check
    $error("radar_sweep_ranger: timing parameters must be nonzero");
  end

  // One counter serves SETTLE, TRIGGER and WAIT_ECHO, so size it for the longest.
  localparam int unsigned CNT_MAX =
    (SETTLE_CYCLES > ECHO_TIMEOUT)
      ? ((SETTLE_CYCLES > TRIG_CYCLES) ? SETTLE_CYCLES : TRIG_CYCLES)
      : ((ECHO_TIMEOUT  > TRIG_CYCLES) ? ECHO_TIMEOUT  : TRIG_CYCLES);
  localparam int unsigned CNT_W = cnt_width(CNT_MAX);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [THETA_W-1:0] theta_q, theta_d;
  logic               dir_up_q, dir_up_d;
  logic               trigger_q, trigger_d;
  logic [RT_W-1:0]    r_theta_q, r_theta_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic               timer_clear, timer_count;
  logic               echo_rise, echo_fall;
  logic [RANGE_W-1:0] echo_range;

  assign timer_clear = (state_q == ST_TRIGGER);
  assign timer_count = (state_q == ST_WAIT_ECHO) ? echo_rise : (state_q == ST_MEASURE);

  echo_pulse_timer #(
    .CYCLES_PER_UNIT(CYCLES_PER_UNIT)
  ) u_echo_timer (
    .clk       (clock),
    .rst_n     (reset_n),
    .echo_async(echo),
    .clear     (timer_clear),
    .count_en  (timer_count),
    .echo_rise (echo_rise),
    .echo_fall (echo_fall),
    .range     (echo_range)
  );

  assign trigger       = trigger_q;
  assign theta_index   = theta_q;
  assign r_theta       = r_theta_q;
  assign r_theta_valid = valid_q;
  assign sweep_done    = done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    theta_d   = theta_q;
    dir_up_d  = dir_up_q;
    trigger_d = 1'b0;
    r_theta_d = r_theta_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d     = '0;
          state_d   = ST_TRIGGER;
          trigger_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_TRIGGER: begin
        if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT_ECHO;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          trigger_d = 1'b1;
        end
      end

      ST_WAIT_ECHO: begin
        if (echo_rise) begin
          cnt_d   = '0;
          state_d = ST_MEASURE;
        end else if (cnt_q == CNT_W'(ECHO_TIMEOUT - 1)) begin
          cnt_d     = '0;
          state_d   = ST_REPORT;
          r_theta_d = pack_r_theta(theta_q, RANGE_MAX);
          valid_d   = 1'b1;
          done_d    = (theta_q == '0) || (theta_q == MAX_THETA_INDEX);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_MEASURE: begin
        if (echo_fall || echo_range == RANGE_MAX) begin
          state_d   = ST_REPORT;
          r_theta_d = pack_r_theta(theta_q, echo_range);
          valid_d   = 1'b1;
          done_d    = (theta_q == '0) || (theta_q == MAX_THETA_INDEX);
        end
      end

      ST_REPORT: begin
        state_d = ST_ADVANCE;
      end

      ST_ADVANCE: begin
        // The end indices flip direction, so neither end is visited twice in a row.
        if (dir_up_q) begin
          if (theta_q >= MAX_THETA_INDEX) begin
            theta_d  = MAX_THETA_INDEX - 1'b1;
            dir_up_d = 1'b0;
          end else begin
            theta_d = theta_q + 1'b1;
            if (theta_d == MAX_THETA_INDEX) begin
              dir_up_d = 1'b0;
            end
          end
        end else begin
          if (theta_q == '0) begin
            theta_d  = 4'd1;
            dir_up_d = 1'b1;
          end else begin
            theta_d = theta_q - 1'b1;
            if (theta_d == '0) begin
              dir_up_d = 1'b1;
            end
          end
        end
        cnt_d   = '0;
        state_d = enable ? ST_SETTLE : ST_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      theta_q   <= '0;
      dir_up_q  <= 1'b1;
      trigger_q <= 1'b0;
      r_theta_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      theta_q   <= theta_d;
      dir_up_q  <= dir_up_d;
      trigger_q <= trigger_d;
      r_theta_q <= r_theta_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

endmodule
